// File: rtl/qenc_dqp_fsm_if.sv
// ---------------------------------------------------------------------------
// qenc_dqp_fsm_if
// Bin stream from the delta-QP binarizer to the CABAC bin encoder.
//   bin_vld      : bin presented (driven by master)
//   bin_val      : bin value (driven by master)
//   bin_ctx_addr : context address, 0 for bypass bins (driven by master)
//   bin_ep       : bypass-mode bin (driven by master)
//   bin_rdy      : encoder accepts the bin when bin_vld & bin_rdy (driven by slave)
// ---------------------------------------------------------------------------
interface qenc_dqp_fsm_if;
    logic       bin_vld;
    logic       bin_val;
    logic [9:0] bin_ctx_addr;
    logic       bin_ep;
    logic       bin_rdy;

    modport master (
        output bin_vld,
        output bin_val,
        output bin_ctx_addr,
        output bin_ep,
        input  bin_rdy
    );

    modport slave (
        input  bin_vld,
        input  bin_val,
        input  bin_ctx_addr,
        input  bin_ep,
        output bin_rdy
    );
endinterface

// File: rtl/qenc_dqp_fsm.sv
// ---------------------------------------------------------------------------
// qdec_cabac_package : CABAC context indices shared with the decoder side.
//
// qenc_dqp_fsm
// Binarizes one coding unit's delta QP (cu_qp_delta_abs + sign flag) and
// streams the bins to the CABAC bin encoder over a valid/ready handshake.
// Prefix is truncated unary (cMax=5, context coded), suffix is EG0 (bypass),
// followed by a bypass sign bin when abs > 0.
//
// Ports:
//   clk                      : clock
//   rst                      : synchronous active-high reset
//   dqp_start                : one-cycle start pulse, honoured only in IDLE
//   cu_qp_delta_enabled_flag : PPS flag, sampled at start
//   cu_qp_delta_val[7:0]     : signed delta QP (-64..+64), sampled at start
//   bin_if (master)          : bin_vld/bin_val/bin_ctx_addr/bin_ep out, bin_rdy in
//   dqp_err                  : one-cycle pulse, sampled value out of range
//   dqp_done_intr            : one-cycle completion pulse
//   dqp_bin_cnt[4:0]         : bins accepted in the current run
//                              (only when QENC_DQP_BIN_CNT_EN is defined)
//
// Optional feature macro: QENC_DQP_BIN_CNT_EN
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for dqp_start
// PREFIX   | truncated-unary prefix bins, context coded
// EG_PFX   | EG0 unary part, bypass
// EG_SFX   | EG0 fixed-length part (k bits, MSB first), bypass
// SIGN     | sign bin, bypass (1 = negative)
// ENDING   | one-cycle tail, completion pulse follows
// ---------------------------------------------------------------------------
package qdec_cabac_package;
    localparam logic [1:0][9:0] CTXIDX_CU_QP_DELTA_ABS = {10'd157, 10'd156};
endpackage

module qenc_dqp_fsm
    import qdec_cabac_package::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          dqp_start,
    input  logic          cu_qp_delta_enabled_flag,
    input  logic [7:0]    cu_qp_delta_val,
    qenc_dqp_fsm_if.master bin_if,
    output logic          dqp_err,
    output logic          dqp_done_intr
`ifdef QENC_DQP_BIN_CNT_EN
    ,
    output logic [4:0]    dqp_bin_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PREFIX = 3'd1,
        S_EG_PFX = 3'd2,
        S_EG_SFX = 3'd3,
        S_SIGN   = 3'd4,
        S_ENDING = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] abs_q,   abs_d;
    logic       sign_q,  sign_d;
    logic [5:0] v_q,     v_d;     // EG0 working value
    logic [2:0] k_q,     k_d;     // EG0 order reached so far
    logic [2:0] idx_q,   idx_d;   // prefix bin index, or suffix bit index
    logic       err_d;
    logic       done_d;
    logic       vld_d;
    logic [11:0] bin_d;           // {val, ctx_addr, ep} of the next presented bin

    logic [7:0] start_mag;
    logic [6:0] start_abs;
    logic       start_legal;
    logic       hs;

    assign start_mag   = cu_qp_delta_val[7] ? (8'd0 - cu_qp_delta_val) : cu_qp_delta_val;
    assign start_abs   = start_mag[6:0];
    // -128 maps to magnitude 128 and is rejected along with anything above 64.
    assign start_legal = (start_mag <= 8'd64);
    assign hs          = bin_if.bin_vld & bin_if.bin_rdy;

    // Bin that a given state/counter combination presents. Used on the next
    // values so the bin outputs come straight out of flops.
    function automatic logic [11:0] bin_decode(
        input state_t     s,
        input logic [6:0] a,
        input logic       sg,
        input logic [5:0] v,
        input logic [2:0] k,
        input logic [2:0] i
    );
        logic [6:0] pw;
        pw         = 7'd1 << k;
        bin_decode = '0;
        case (s)
            S_PREFIX: bin_decode = {({4'd0, i} < a),
                                    (i == 3'd0) ? CTXIDX_CU_QP_DELTA_ABS[0]
                                                : CTXIDX_CU_QP_DELTA_ABS[1],
                                    1'b0};
            S_EG_PFX: bin_decode = {({1'b0, v} >= pw), 10'd0, 1'b1};
            S_EG_SFX: bin_decode = {v[i], 10'd0, 1'b1};
            S_SIGN:   bin_decode = {sg, 10'd0, 1'b1};
            default:  bin_decode = '0;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        abs_d   = abs_q;
        sign_d  = sign_q;
        v_d     = v_q;
        k_d     = k_q;
        idx_d   = idx_q;
        err_d   = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (dqp_start) begin
                    abs_d  = start_abs;
                    sign_d = cu_qp_delta_val[7];
                    v_d    = start_abs[5:0] - 6'd5;
                    k_d    = 3'd0;
                    idx_d  = 3'd0;
                    if (!cu_qp_delta_enabled_flag) begin
                        state_d = S_ENDING;
                    end else if (!start_legal) begin
                        state_d = S_ENDING;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_PREFIX;
                    end
                end
            end

            S_PREFIX: begin
                if (hs) begin
                    // Prefix ends on the 5th one or on the terminating zero.
                    if ((idx_q == 3'd4) || !bin_if.bin_val) begin
                        if (abs_q >= 7'd5) begin
                            state_d = S_EG_PFX;
                        end else if (abs_q != 7'd0) begin
                            state_d = S_SIGN;
                        end else begin
                            state_d = S_ENDING;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end

            S_EG_PFX: begin
                if (hs) begin
                    if (bin_if.bin_val) begin
                        v_d = v_q - (6'd1 << k_q);
                        k_d = k_q + 3'd1;
                    end else if (k_q != 3'd0) begin
                        state_d = S_EG_SFX;
                        idx_d   = k_q - 3'd1;
                    end else begin
                        state_d = S_SIGN;
                    end
                end
            end

            S_EG_SFX: begin
                if (hs) begin
                    if (idx_q == 3'd0) begin
                        state_d = S_SIGN;
                    end else begin
                        idx_d = idx_q - 3'd1;
                    end
                end
            end

            S_SIGN: begin
                if (hs) begin
                    state_d = S_ENDING;
                end
            end

            S_ENDING: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        vld_d = (state_d == S_PREFIX) || (state_d == S_EG_PFX) ||
                (state_d == S_EG_SFX) || (state_d == S_SIGN);
        bin_d = bin_decode(state_d, abs_d, sign_d, v_d, k_d, idx_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q             <= S_IDLE;
            abs_q               <= '0;
            sign_q              <= 1'b0;
            v_q                 <= '0;
            k_q                 <= '0;
            idx_q               <= '0;
            dqp_err             <= 1'b0;
            dqp_done_intr       <= 1'b0;
            bin_if.bin_vld      <= 1'b0;
            bin_if.bin_val      <= 1'b0;
            bin_if.bin_ctx_addr <= '0;
            bin_if.bin_ep       <= 1'b0;
        end else begin
            state_q             <= state_d;
            abs_q               <= abs_d;
            sign_q              <= sign_d;
            v_q                 <= v_d;
            k_q                 <= k_d;
            idx_q               <= idx_d;
            dqp_err             <= err_d;
            dqp_done_intr       <= done_d;
            bin_if.bin_vld      <= vld_d;
            bin_if.bin_val      <= bin_d[11];
            bin_if.bin_ctx_addr <= bin_d[10:1];
            bin_if.bin_ep       <= bin_d[0];
        end
    end

`ifdef QENC_DQP_BIN_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            dqp_bin_cnt <= '0;
        end else if ((state_q == S_IDLE) && dqp_start) begin
            dqp_bin_cnt <= '0;
        end else if (hs) begin
            dqp_bin_cnt <= dqp_bin_cnt + 5'd1;
        end
    end
`endif

endmodule

// File: tb/tb_qenc_dqp_fsm.sv
// ---------------------------------------------------------------------------
// tb_qenc_dqp_fsm
// Bench for qenc_dqp_fsm: a vector table of directed delta-QP runs, hand
// sequences for reset corner cases, and randomized runs, all checked against
// an arithmetic model of the TU + EG0 + sign binarization.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_qenc_dqp_fsm;
    import qdec_cabac_package::*;

    logic       clk;
    logic       rst;
    logic       dqp_start;
    logic       en;
    logic [7:0] val;
    logic       dqp_err;
    logic       dqp_done_intr;
`ifdef QENC_DQP_BIN_CNT_EN
    logic [4:0] dqp_bin_cnt;
`endif

    qenc_dqp_fsm_if bif();

    qenc_dqp_fsm dut (
        .clk                      (clk),
        .rst                      (rst),
        .dqp_start                (dqp_start),
        .cu_qp_delta_enabled_flag (en),
        .cu_qp_delta_val          (val),
        .bin_if                   (bif),
        .dqp_err                  (dqp_err),
        .dqp_done_intr            (dqp_done_intr)
`ifdef QENC_DQP_BIN_CNT_EN
        ,
        .dqp_bin_cnt              (dqp_bin_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [9:0] ctx;
        logic       ep;
    } bin_t;

    typedef struct {
        int v;
        bit e;
        int rdy_pct;
        int nbins;
        bit err;
    } vec_t;

    bin_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    endtask

    function automatic void push_bin(input logic bv, input logic [9:0] c, input logic e);
        bin_t b;
        b.v   = bv;
        b.ctx = c;
        b.ep  = e;
        exp_q.push_back(b);
    endfunction

    // Reference binarization. EG0 is derived from the closed form:
    // m = sfx+1, k = floor(log2 m), k ones, a zero, then k bits of m - 2^k.
    function automatic void build_model(input int v, input bit e);
        int a, m, k, r;
        exp_q.delete();
        if (!e || v < -64 || v > 64) return;
        a = (v < 0) ? -v : v;
        for (int i = 0; i < 5 && i < a; i++)
            push_bin(1'b1, (i == 0) ? CTXIDX_CU_QP_DELTA_ABS[0] : CTXIDX_CU_QP_DELTA_ABS[1], 1'b0);
        if (a < 5) begin
            push_bin(1'b0, (a == 0) ? CTXIDX_CU_QP_DELTA_ABS[0] : CTXIDX_CU_QP_DELTA_ABS[1], 1'b0);
        end else begin
            m = a - 4;
            k = 0;
            while ((m >> (k + 1)) != 0) k++;
            r = m - (1 << k);
            for (int i = 0; i < k; i++) push_bin(1'b1, 10'd0, 1'b1);
            push_bin(1'b0, 10'd0, 1'b1);
            for (int j = k - 1; j >= 0; j--) push_bin(((r >> j) & 1) == 1, 10'd0, 1'b1);
        end
        if (a > 0) push_bin(v < 0, 10'd0, 1'b1);
    endfunction

    // Runs one start; sample s counts cycles after the start was driven.
    task automatic run_case(input string nm, input int v, input bit e, input int pct,
                            input int nb, input bit exp_err);
        int  s, idx, last_s, done_s, done_cnt, extra_err, done_exp;
        bit  stalled, rdy;
        int  held;
        build_model(v, e);
        val       = 8'(v);
        en        = e;
        dqp_start = 1'b1;
        bif.bin_rdy = 1'b0;
        tick();
        s         = 1;
        dqp_start = 1'b0;
        val       = 8'($urandom);
        en        = 1'($urandom);
        chk({nm, " first_vld"}, int'(bif.bin_vld), int'(nb > 0));
        chk({nm, " err"}, int'(dqp_err), int'(exp_err));
        idx = 0; last_s = -1; done_s = -1; done_cnt = 0; extra_err = 0;
        stalled = 1'b0; held = 0;
        while (s < 400) begin
            if (s > 1 && dqp_err) extra_err++;
            if (dqp_done_intr) begin
                done_cnt++;
                if (done_s < 0) done_s = s;
            end
            if (stalled)
                chk({nm, " stall_stable"},
                    int'({bif.bin_vld, bif.bin_val, bif.bin_ctx_addr, bif.bin_ep}), held);
            stalled = 1'b0;
            rdy = ($urandom_range(1, 100) <= pct);
            bif.bin_rdy = rdy;
            if (bif.bin_vld) begin
                if (rdy) begin
                    if (idx < exp_q.size())
                        chk($sformatf("%s bin%0d", nm, idx),
                            int'({bif.bin_val, bif.bin_ctx_addr, bif.bin_ep}),
                            int'({exp_q[idx].v, exp_q[idx].ctx, exp_q[idx].ep}));
                    else
                        chk({nm, " extra_bin"}, 1, 0);
                    idx++;
                    if (idx == exp_q.size()) last_s = s;
                end else begin
                    stalled = 1'b1;
                    held = int'({1'b1, bif.bin_val, bif.bin_ctx_addr, bif.bin_ep});
                end
            end
            if (done_s >= 0 && s >= done_s + 3) break;
            tick();
            s++;
        end
        bif.bin_rdy = 1'b0;
        done_exp = (nb == 0) ? 2 : last_s + 2;
        chk({nm, " nbins"}, idx, nb);
        chk({nm, " done_at"}, done_s, done_exp);
        chk({nm, " done_cnt"}, done_cnt, 1);
        chk({nm, " extra_err"}, extra_err, 0);
`ifdef QENC_DQP_BIN_CNT_EN
        chk({nm, " bin_cnt"}, int'(dqp_bin_cnt), nb);
`endif
    endtask

    vec_t vecs[12];

    initial begin
        int accepted, dn, rv;
        bit re;
        vecs[0]  = '{  3, 1'b0, 100,  0, 1'b0};
        vecs[1]  = '{  0, 1'b1, 100,  1, 1'b0};
        vecs[2]  = '{ -3, 1'b1, 100,  5, 1'b0};
        vecs[3]  = '{  7, 1'b1, 100,  9, 1'b0};
        vecs[4]  = '{-64, 1'b1,  45, 17, 1'b0};
        vecs[5]  = '{100, 1'b1, 100,  0, 1'b1};
        vecs[6]  = '{-65, 1'b1, 100,  0, 1'b1};
        vecs[7]  = '{ 64, 1'b1,  70, 17, 1'b0};
        vecs[8]  = '{  4, 1'b1, 100,  6, 1'b0};
        vecs[9]  = '{  5, 1'b1, 100,  7, 1'b0};
        vecs[10] = '{ -1, 1'b1,  60,  3, 1'b0};
        vecs[11] = '{-100, 1'b0, 100, 0, 1'b0};

        rst = 1'b1; dqp_start = 1'b0; en = 1'b0; val = '0; bif.bin_rdy = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst bin_vld", int'(bif.bin_vld), 0);
        chk("rst bin_val", int'(bif.bin_val), 0);
        chk("rst bin_ep", int'(bif.bin_ep), 0);
        chk("rst ctx", int'(bif.bin_ctx_addr), 0);
        chk("rst err", int'(dqp_err), 0);
        chk("rst done", int'(dqp_done_intr), 0);
`ifdef QENC_DQP_BIN_CNT_EN
        chk("rst bin_cnt", int'(dqp_bin_cnt), 0);
`endif

        foreach (vecs[i])
            run_case($sformatf("vec%0d", i), vecs[i].v, vecs[i].e, vecs[i].rdy_pct,
                     vecs[i].nbins, vecs[i].err);

        // Reset after the third accepted bin of +7.
        val = 8'd7; en = 1'b1; dqp_start = 1'b1; bif.bin_rdy = 1'b1;
        tick();
        dqp_start = 1'b0;
        accepted = 0;
        for (int i = 0; i < 20 && accepted < 3; i++) begin
            if (bif.bin_vld) accepted++;
            tick();
        end
        chk("mid_rst accepted", accepted, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst vld", int'(bif.bin_vld), 0);
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            if (dqp_done_intr || bif.bin_vld) dn++;
            tick();
        end
        chk("mid_rst quiet", dn, 0);
        bif.bin_rdy = 1'b0;
        run_case("post_rst", 7, 1'b1, 100, 9, 1'b0);

        // Start coincident with reset is ignored.
        rst = 1'b1; val = 8'd7; en = 1'b1; dqp_start = 1'b1;
        tick();
        rst = 1'b0; dqp_start = 1'b0;
        dn = 0;
        for (int i = 0; i < 5; i++) begin
            if (dqp_done_intr || bif.bin_vld || dqp_err) dn++;
            tick();
        end
        chk("start_in_rst quiet", dn, 0);

        // Randomized runs.
        for (int t = 0; t < 40; t++) begin
            rv = int'($urandom_range(0, 140)) - 70;
            re = ($urandom_range(0, 9) != 0);
            build_model(rv, re);
            run_case($sformatf("rnd%0d_v%0d", t, rv), rv, re, int'($urandom_range(30, 100)),
                     exp_q.size(), re && (rv < -64 || rv > 64));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/qenc_dqp_fsm.md
# qenc_dqp_fsm

CABAC encoder-side sub-FSM that binarizes one coding unit's delta QP (`cu_qp_delta_abs` plus `cu_qp_delta_sign_flag`) and streams the resulting bins to the CABAC bin encoder. It uses a valid/ready handshake and supplies a context address and bypass flag with every bin. It sits under the encoder CU-level FSM, which starts it once per quantization group and waits for its done interrupt.

## Interface
- No parameters. Context indices come from `CTXIDX_CU_QP_DELTA_ABS[0..1]` in `qdec_cabac_package`.
- `clk`  input  1  clock.
- `rst`  input  1  reset, synchronous, active-high.
- `dqp_start`  input  1  one-cycle start pulse; honoured only in IDLE.
- `cu_qp_delta_enabled_flag`  input  1  PPS flag; sampled at start.
- `cu_qp_delta_val`  input  8  signed delta QP, legal range −64..+64; sampled at start.
- `bin_vld`  output  1  bin presented.
- `bin_val`  output  1  bin value.
- `bin_ctx_addr`  output  10  context address; 0 when `bin_ep`=1.
- `bin_ep`  output  1  bypass-mode bin.
- `bin_rdy`  input  1  encoder accepts the bin when `bin_vld`&`bin_rdy`.
- `dqp_err`  output  1  one-cycle pulse: sampled value is outside the legal range.
- `dqp_done_intr`  output  1  one-cycle completion pulse.

## Operation
- Capture at start:
  - `abs` = |val|, 7 bits.
  - `sign` = val[7].
  - `sfx` = abs−5, 6 bits, valid when abs≥5.
- States and transitions:
  - IDLE → PREFIX on start, enabled, and legal value.
  - IDLE → ENDING on start and not enabled.
  - IDLE → ENDING on start, enabled, and illegal value; `dqp_err` pulses in the cycle the state enters ENDING.
  - PREFIX emits TU bins, cMax=5: min(abs,5) ones, then a 0 if abs<5. Context bins: bin 0 uses `CTXIDX_CU_QP_DELTA_ABS[0]`; bins 1..4 use `[1]`.
  - PREFIX → EG_PFX if abs≥5; else → SIGN if abs>0; else → ENDING.
  - EG_PFX emits the EG0 unary part in bypass. Working value v=sfx, k=0. While v ≥ 2^k: emit 1, v −= 2^k, k++. Then emit 0.
  - EG_PFX → EG_SFX if k>0, else → SIGN.
  - EG_SFX emits the k low bits of v in bypass, MSB first, then → SIGN.
  - SIGN emits one bypass bin (1 = negative), then → ENDING.
  - ENDING lasts one cycle, then → IDLE.
- Bin limits: at most 17 bins. The bin counter is 5 bits; k is at most 5.
- Outputs are registered from state and counters. A bin advances only on handshake.
- `bin_vld`, `bin_val`, `bin_ctx_addr`, and `bin_ep` stay stable while `bin_vld`&!`bin_rdy`.
- `dqp_start` outside IDLE is ignored. Input changes after start have no effect.

## Timing
- Reset values: state IDLE; `bin_vld`, `bin_val`, `bin_ep`, `dqp_err`, and `dqp_done_intr` all 0; `bin_ctx_addr` 0.
- Start at cycle T → first `bin_vld` at T+1.
- With `bin_rdy` held high: one bin per cycle, no bubbles between states.
- Last bin accepted at cycle A → ENDING at A+1 → `dqp_done_intr` high at A+2 for exactly one cycle.
- Disabled or illegal value: start at T → `dqp_done_intr` at T+2, no bins emitted.
- `bin_rdy` low stalls indefinitely with no bin loss or duplication.
- `rst` mid-operation: IDLE on the next cycle, `bin_vld`=0, no done pulse.
- Start coincident with `rst`: ignored.

## Configuration
- `QENC_DQP_BIN_CNT_EN` defined:
  - Adds output `dqp_bin_cnt` [4:0]: bins accepted in the current run.
  - Cleared at start; holds its final value until the next start; reset to 0.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Disabled flag, val=+3 → no bins; done pulse at T+2.
- val=0 → single bin 0 on ctx[0], ep=0; no sign bin; done pulse 2 cycles after acceptance.
- val=−3 → bins 1,1,1,0 (ctx[0],[1],[1],[1]), then sign bin 1 (ep=1); 5 bins total.
- val=+7 → prefix 11111 (context-coded), then bypass 1,0,1, then sign 0; 9 bins, `dqp_bin_cnt`=9 when the macro is enabled.
- val=−64 with random `bin_rdy` stalls → prefix 11111, EG0 of 59 = 111110 11100, sign 1; 17 bins with outputs stable during stalls; then val=+100 → `dqp_err` pulse, no bins, done pulse.
- `rst` asserted after the 3rd bin of val=+7 → `bin_vld` low next cycle, no done pulse; a fresh start afterwards encodes correctly.
